// File: rtl/jtopll_wrq.sv
// jtopll_wrq: CPU write queue that replays register writes to an OPLL core in order,
// holding off after each write for an address or data settle time counted in cen ticks.
//
// state | meaning
// IDLE  | queue empty and no hold-off running
// ISSUE | head entry is latched onto addr/din and popped at the next edge
// WAIT  | hold-off after a write; wcnt counts down on cen
module jtopll_wrq #(
  parameter int DEPTH     = 4,
  parameter int ADDR_WAIT = 12,
  parameter int DATA_WAIT = 84
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       cpu_addr,
  input  logic [7:0] cpu_din,
  input  logic       cpu_wr,
  output logic       cpu_busy,
  output logic       ovf,
  output logic       pending,
  output logic       write,
  output logic       addr,
  output logic [7:0] din
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int WMAX = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
  localparam int WW   = (WMAX < 1) ? 1 : $clog2(WMAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [8:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [WW-1:0] r_wcnt;
  logic          r_write;
  logic          r_addr;
  logic [7:0]    r_din;
  logic          r_ovf;

  logic          w_full;
  logic          w_push;
  logic          w_drop;
  logic          w_pop;
  logic [8:0]    w_head;

  // Full is judged on the registered count, so a pop on the same edge never rescues a push.
  assign w_full = (r_count == CW'(DEPTH));
  assign w_push = cpu_wr & ~w_full;
  assign w_drop = cpu_wr & w_full;
  assign w_pop  = (r_state == S_ISSUE);
  assign w_head = r_mem[r_rptr];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (r_count != '0) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (r_wcnt == '0) w_state_nxt = (r_count != '0) ? S_ISSUE : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_wcnt  <= '0;
      r_write <= 1'b0;
      r_addr  <= 1'b0;
      r_din   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_write <= w_pop;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
        r_addr <= w_head[8];
        r_din  <= w_head[7:0];
        r_wcnt <= w_head[8] ? WW'(DATA_WAIT) : WW'(ADDR_WAIT);
      end else if (r_state == S_WAIT && cen && r_wcnt != '0) begin
        r_wcnt <= r_wcnt - 1'b1;
      end
      if (w_drop) r_ovf <= 1'b1;
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wptr] <= {cpu_addr, cpu_din};
  end

  assign cpu_busy = w_full;
  assign ovf      = r_ovf;
  assign pending  = (r_count != '0) || (r_state != S_IDLE);
  assign write    = r_write;
  assign addr     = r_addr;
  assign din      = r_din;

endmodule

// File: tb/tb_jtopll_wrq.sv
// Bench for jtopll_wrq: a default-wait instance and a zero-wait instance share one stimulus
// stream; each has its own queue-based reference model and a scoreboard monitor.
module tb_jtopll_wrq;

  logic       clk = 1'b0;
  logic       rst;
  logic       cen;
  logic       cpu_addr;
  logic [7:0] cpu_din;
  logic       cpu_wr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int AWT = (g == 0) ? 12 : 0;
    localparam int DWT = (g == 0) ? 84 : 0;
    localparam int DEP = 4;

    logic       busy;
    logic       ovf_o;
    logic       pend;
    logic       wr_o;
    logic       addr_o;
    logic [7:0] din_o;

    jtopll_wrq #(.DEPTH(DEP), .ADDR_WAIT(AWT), .DATA_WAIT(DWT)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .cen      (cen),
      .cpu_addr (cpu_addr),
      .cpu_din  (cpu_din),
      .cpu_wr   (cpu_wr),
      .cpu_busy (busy),
      .ovf      (ovf_o),
      .pending  (pend),
      .write    (wr_o),
      .addr     (addr_o),
      .din      (din_o)
    );

    // Reference: a queue of accepted entries; "phase" is 0 when nothing is in flight,
    // 1 when the head is due to go out at the next edge, 2 while the hold-off runs.
    logic [8:0] fifo[$];
    logic [8:0] exp_v[$];
    int         exp_t[$];
    int         m_edge = 0;
    int         phase;
    int         left;
    bit         m_ovf;
    logic [8:0] m_last;

    initial begin : model
      int         pre;
      logic [8:0] h;
      phase  = 0;
      left   = 0;
      m_ovf  = 1'b0;
      m_last = '0;
      forever begin
        @(posedge clk);
        m_edge++;
        if (rst) begin
          fifo.delete();
          exp_v.delete();
          exp_t.delete();
          phase  = 0;
          left   = 0;
          m_ovf  = 1'b0;
          m_last = '0;
        end else begin
          pre = fifo.size();
          if (phase == 1) begin
            h      = fifo.pop_front();
            m_last = h;
            exp_v.push_back(h);
            exp_t.push_back(m_edge);
            left   = h[8] ? DWT : AWT;
            phase  = 2;
          end else if (phase == 0 || left == 0) begin
            phase = (pre != 0) ? 1 : 0;
          end else if (cen) begin
            left--;
          end
          if (cpu_wr) begin
            if (pre < DEP) fifo.push_back({cpu_addr, cpu_din});
            else m_ovf = 1'b1;
          end
        end
      end
    end

    initial begin : monitor
      bit         ew;
      logic [8:0] v;
      forever begin
        @(negedge clk);
        if (m_edge > 0) begin
          ew = (exp_t.size() > 0) && (exp_t[0] == m_edge);
          checks++;
          if (wr_o !== ew) begin
            failures++;
            $display("FAIL write_strobe inst=%0d edge=%0d got=%b want=%b", g, m_edge, wr_o, ew);
          end
          if (ew) begin
            v = exp_v.pop_front();
            void'(exp_t.pop_front());
            if (wr_o === 1'b1) begin
              checks++;
              if ({addr_o, din_o} !== v) begin
                failures++;
                $display("FAIL issue_entry inst=%0d edge=%0d got=%h want=%h", g, m_edge, {addr_o, din_o}, v);
              end
            end
          end
          checks++;
          if ({addr_o, din_o} !== m_last) begin
            failures++;
            $display("FAIL addr_din_hold inst=%0d edge=%0d got=%h want=%h", g, m_edge, {addr_o, din_o}, m_last);
          end
          checks++;
          if (busy !== (fifo.size() == DEP)) begin
            failures++;
            $display("FAIL cpu_busy inst=%0d edge=%0d got=%b want=%b", g, m_edge, busy, fifo.size() == DEP);
          end
          checks++;
          if (ovf_o !== m_ovf) begin
            failures++;
            $display("FAIL ovf inst=%0d edge=%0d got=%b want=%b", g, m_edge, ovf_o, m_ovf);
          end
          checks++;
          if (pend !== (fifo.size() != 0 || phase != 0)) begin
            failures++;
            $display("FAIL pending inst=%0d edge=%0d got=%b want=%b", g, m_edge, pend,
                     fifo.size() != 0 || phase != 0);
          end
        end
      end
    end
  end

  task automatic step(input bit w, input bit a, input logic [7:0] d, input bit c);
    cpu_wr   = w;
    cpu_addr = a;
    cpu_din  = d;
    cen      = c;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input int cen_div);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, (i % cen_div) == cen_div - 1);
  endtask

  task automatic rand_traffic(input int n);
    for (int i = 0; i < n; i++)
      step($urandom_range(0, 6) == 0, 1'($urandom), 8'($urandom), $urandom_range(0, 3) != 0);
  endtask

  initial begin
    rst      = 1'b1;
    cen      = 1'b1;
    cpu_wr   = 1'b0;
    cpu_addr = 1'b0;
    cpu_din  = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(2, 1);

    // single address write, cen always on
    step(1'b1, 1'b0, 8'h30, 1'b1);
    idle(20, 1);

    // address then data write, cen every 4th clk
    step(1'b1, 1'b0, 8'h10, 1'b0);
    step(1'b1, 1'b1, 8'h55, 1'b0);
    idle(420, 4);

    // overflow with cen held low, then drain
    for (int i = 0; i < 6; i++) step(1'b1, 1'(i), 8'(8'hA0 + i), 1'b0);
    idle(10, 1000);
    idle(500, 1);

    // dense random traffic: exercises push/pop on the same edge and full drops
    rand_traffic(2500);
    idle(600, 1);

    // reset while entries are queued and a hold-off is running, with a write on the reset edge
    step(1'b1, 1'b1, 8'h11, 1'b1);
    step(1'b1, 1'b0, 8'h22, 1'b1);
    step(1'b1, 1'b1, 8'h33, 1'b1);
    idle(4, 1);
    rst = 1'b1;
    step(1'b1, 1'b1, 8'hEE, 1'b1);
    rst = 1'b0;
    idle(3, 1);
    rand_traffic(300);
    idle(700, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
